// File: rtl/daq_wb_master.sv
// Single-cycle Wishbone B3 classic master driven by the DAQ file-access state machine.
// Optional bus timeout enabled by defining DAQ_WB_TIMEOUT_EN.
module daq_wb_master #(
  parameter int unsigned dw             = 32,
  parameter int unsigned aw             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          start,
  input  logic [aw-1:0] address,
  input  logic [3:0]    selection,
  input  logic          write,
  input  logic [dw-1:0] data_wr,
  output logic          active,
  output logic [dw-1:0] data_rd,
  output logic          bus_err,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          active_q, active_d;
  logic [dw-1:0] data_rd_q, data_rd_d;
  logic          bus_err_q, bus_err_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [dw-1:0] dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;

`ifdef DAQ_WB_TIMEOUT_EN
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    data_rd_d = data_rd_q;
    bus_err_d = 1'b0;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
`ifdef DAQ_WB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        active_d = 1'b0;
        cyc_d    = 1'b0;
        if (start) begin
          adr_d    = address;
          sel_d    = selection;
          we_d     = write;
          dat_d    = data_wr;
          cyc_d    = 1'b1;
          active_d = 1'b1;
          state_d  = BUS;
`ifdef DAQ_WB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      BUS: begin
`ifdef DAQ_WB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        // err outranks ack; either outranks the timeout
        if (wb_err_i) begin
          cyc_d     = 1'b0;
          active_d  = 1'b0;
          data_rd_d = '0;
          bus_err_d = 1'b1;
          state_d   = RELEASE;
        end else if (wb_ack_i) begin
          cyc_d    = 1'b0;
          active_d = 1'b0;
          if (!we_q) data_rd_d = wb_dat_i;
          state_d  = RELEASE;
        end
`ifdef DAQ_WB_TIMEOUT_EN
        else if (tmo_hit) begin
          cyc_d     = 1'b0;
          active_d  = 1'b0;
          data_rd_d = '1;
          bus_err_d = 1'b1;
          state_d   = RELEASE;
        end
`endif
      end
      RELEASE: begin
        cyc_d    = 1'b0;
        active_d = 1'b0;
        if (!start) state_d = IDLE;
      end
      default: begin
        cyc_d    = 1'b0;
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      data_rd_q <= '0;
      bus_err_q <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      data_rd_q <= data_rd_d;
      bus_err_q <= bus_err_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
    end
  end

`ifdef DAQ_WB_TIMEOUT_EN
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) tmo_cnt_q <= '0;
    else           tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign active   = active_q;
  assign data_rd  = data_rd_q;
  assign bus_err  = bus_err_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule

// File: tb/tb_daq_wb_master.sv
// Directed bench for daq_wb_master; timeout scenario follows DAQ_WB_TIMEOUT_EN.
module tb_daq_wb_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        start;
  logic [31:0] address;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr;
  logic        active;
  logic [31:0] data_rd;
  logic        bus_err;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk = ~wb_clk;

  daq_wb_master #(
    .dw(32),
    .aw(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .start(start), .address(address),
    .selection(selection), .write(write), .data_wr(data_wr), .active(active),
    .data_rd(data_rd), .bus_err(bus_err), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    int n;
    logic ok;
    wb_rst_n = 1'b0; start = 1'b0; address = '0; selection = '0; write = 1'b0;
    data_wr = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #12;
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_data_rd", data_rd, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    wb_rst_n = 1'b1;
    step();

    // read, ack sampled on the third edge after stb
    start = 1'b1; address = 32'h0000_0020; selection = 4'hF; write = 1'b0;
    step();
    chk("rd_active", {31'd0, active}, 32'd1);
    chk("rd_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
    chk("rd_adr", wb_adr_o, 32'h20);
    chk("rd_we", {31'd0, wb_we_o}, 32'd0);
    chk("rd_sel", {28'd0, wb_sel_o}, 32'hF);
    address = 32'h0000_0444;
    step();
    chk("rd_cyc2", {31'd0, wb_cyc_o}, 32'd1);
    chk("rd_adr_hold", wb_adr_o, 32'h20);
    step();
    chk("rd_cyc3", {31'd0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    chk("rd_done_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("rd_done_active", {31'd0, active}, 32'd0);
    chk("rd_data", data_rd, 32'h1234_5678);
    chk("rd_no_err", {31'd0, bus_err}, 32'd0);
    step();
    chk("rd_release_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rd_release_data", data_rd, 32'h1234_5678);
    start = 1'b0;
    step();

    // write with immediate ack and start held afterwards
    start = 1'b1; write = 1'b1; data_wr = 32'hCAFE_F00D; selection = 4'h3; address = 32'h100;
    step();
    chk("wr_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("wr_dat", wb_dat_o, 32'hCAFE_F00D);
    chk("wr_sel", {28'd0, wb_sel_o}, 32'h3);
    chk("wr_we", {31'd0, wb_we_o}, 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    step();
    wb_ack_i = 1'b0;
    chk("wr_done_active", {31'd0, active}, 32'd0);
    chk("wr_data_rd_kept", data_rd, 32'h1234_5678);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (wb_cyc_o !== 1'b0 || active !== 1'b0) ok = 1'b0;
      step();
    end
    chk("wr_no_relaunch", {31'd0, ok}, 32'd1);
    chk("wr_dat_hold", wb_dat_o, 32'hCAFE_F00D);
    start = 1'b0;
    step();
    chk("wr_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
    start = 1'b1; data_wr = 32'h0BAD_BEEF;
    step();
    chk("wr2_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("wr2_dat", wb_dat_o, 32'h0BAD_BEEF);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0; start = 1'b0;
    step();

    // error and ack together: error wins
    start = 1'b1; write = 1'b0; address = 32'h40; selection = 4'hF;
    step();
    wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_DEAD;
    step();
    wb_err_i = 1'b0; wb_ack_i = 1'b0;
    chk("err_data_rd", data_rd, 32'd0);
    chk("err_pulse", {31'd0, bus_err}, 32'd1);
    chk("err_active", {31'd0, active}, 32'd0);
    chk("err_cyc", {31'd0, wb_cyc_o}, 32'd0);
    step();
    chk("err_pulse_end", {31'd0, bus_err}, 32'd0);
    start = 1'b0;
    step();

    // asynchronous reset in the middle of BUS
    start = 1'b1; address = 32'h80;
    step();
    chk("ar_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("ar_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("ar_active", {31'd0, active}, 32'd0);
    chk("ar_adr", wb_adr_o, 32'd0);
    start = 1'b0;
    step();
    wb_rst_n = 1'b1;
    step();
    start = 1'b1; address = 32'h84;
    step();
    chk("ar_new_adr", wb_adr_o, 32'h84);
    wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_5A5A;
    step();
    wb_ack_i = 1'b0; start = 1'b0;
    chk("ar_new_data", data_rd, 32'hA5A5_5A5A);
    step();

    // slave that never responds
    start = 1'b1; address = 32'hC0;
    step();
`ifdef DAQ_WB_TIMEOUT_EN
    n = 0;
    while (wb_cyc_o === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk("to_cyc_cycles", n, 32'd8);
    chk("to_data_rd", data_rd, 32'hFFFF_FFFF);
    chk("to_err_pulse", {31'd0, bus_err}, 32'd1);
    chk("to_active", {31'd0, active}, 32'd0);
    step();
    chk("to_err_end", {31'd0, bus_err}, 32'd0);
    start = 1'b0;
    step();
`else
    n = 0;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (wb_cyc_o !== 1'b1 || active !== 1'b1 || bus_err !== 1'b0) ok = 1'b0;
      step();
    end
    chk("nto_still_bus", {31'd0, ok}, 32'd1);
    chk("nto_data_rd", data_rd, 32'hA5A5_5A5A);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000_0C0C;
    step();
    wb_ack_i = 1'b0; start = 1'b0;
    chk("nto_finish", data_rd, 32'h0000_0C0C);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
